// File: rtl/fp_to_int.sv
// fp_to_int: three-stage pipelined float -> signed integer converter.
// Packed input {sign, exp[NX-1:0], mant[NM-1:0]}; rounding truncates toward zero.
// The whole pipeline advances only when the output register is free or being drained.
//
// Stages:
//   S1 | unpack, classify (zero/denormal, normal, inf, NaN), unbiased exponent
//   S2 | align magnitude, collect discarded fraction bits, range check
//   S3 | negate / saturate, registered outputs
module fp_to_int #(
    parameter int NX   = 8,
    parameter int NM   = 23,
    parameter int NINT = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NX+NM:0]    in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NINT-1:0]   out_data,
    output logic              out_invalid,
    output logic              out_overflow,
    output logic              out_inexact
);

    // Shifter wide enough for the full significand and the full integer range.
    localparam int W    = (NM + 1 > NINT) ? NM + 1 : NINT;
    localparam int BIAS = 2 ** (NX - 1) - 1;

    localparam logic [NM:0]     M_ONES  = '1;
    localparam logic [NINT-1:0] MAX_POS = {1'b0, {(NINT-1){1'b1}}};
    localparam logic [NINT-1:0] MIN_NEG = {1'b1, {(NINT-1){1'b0}}};

    logic                w_en;
    logic [NX-1:0]       w_exp;
    logic [NM-1:0]       w_mant;
    logic signed [31:0]  w_e;

    logic                r1_valid;
    logic                r1_sign;
    logic                r1_nan;
    logic                r1_inf;
    logic                r1_zero;
    logic [NM-1:0]       r1_mant;
    logic signed [31:0]  r1_e;

    logic [NM:0]         w_m;
    logic [W-1:0]        w_mag;
    logic                w_inexact;
    logic                w_sat;
    logic                w_min;

    logic                r2_valid;
    logic                r2_sign;
    logic                r2_invalid;
    logic                r2_sat;
    logic                r2_min;
    logic                r2_inexact;
    logic [W-1:0]        r2_mag;

    logic [NINT-1:0]     w_mag_n;
    logic [NINT-1:0]     w_result;

    logic                r_out_valid;
    logic [NINT-1:0]     r_out_data;
    logic                r_out_invalid;
    logic                r_out_overflow;
    logic                r_out_inexact;

    assign w_en     = !(r_out_valid && !out_ready);
    assign in_ready = w_en;

    assign w_exp  = in_data[NX+NM-1:NM];
    assign w_mant = in_data[NM-1:0];
    assign w_e    = $signed({{(32-NX){1'b0}}, w_exp}) - 32'(BIAS);

    // S1: capture the word and classify it by exponent/mantissa pattern.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r1_valid <= 1'b0;
            r1_sign  <= 1'b0;
            r1_nan   <= 1'b0;
            r1_inf   <= 1'b0;
            r1_zero  <= 1'b0;
            r1_mant  <= '0;
            r1_e     <= '0;
        end else if (w_en) begin
            r1_valid <= in_valid;
            r1_sign  <= in_data[NX+NM];
            r1_nan   <= (&w_exp) && (|w_mant);
            r1_inf   <= (&w_exp) && !(|w_mant);
            r1_zero  <= !(|w_exp);
            r1_mant  <= w_mant;
            r1_e     <= w_e;
        end
    end

    // S2 datapath: alignment shift, lost-bit detection and range decisions.
    always_comb begin
        w_m       = {1'b1, r1_mant};
        w_mag     = '0;
        w_inexact = 1'b0;
        w_sat     = 1'b0;
        w_min     = 1'b0;
        if (r1_nan) begin
            w_mag = '0;
        end else if (r1_inf) begin
            w_sat = 1'b1;
        end else if (r1_zero) begin
            w_inexact = |r1_mant;
        end else if (r1_e < 0) begin
            w_inexact = 1'b1;
        end else if (r1_e >= NINT - 1) begin
            // -2^(NINT-1) is the one representable value at this exponent.
            if (r1_sign && (r1_e == NINT - 1) && !(|r1_mant))
                w_min = 1'b1;
            else
                w_sat = 1'b1;
        end else if (r1_e >= NM) begin
            w_mag = W'(w_m) << (r1_e - NM);
        end else begin
            w_mag     = W'(w_m >> (NM - r1_e));
            w_inexact = |(w_m & ~(M_ONES << (NM - r1_e)));
        end
    end

    // S2: register the aligned magnitude and the decisions for the output stage.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r2_valid   <= 1'b0;
            r2_sign    <= 1'b0;
            r2_invalid <= 1'b0;
            r2_sat     <= 1'b0;
            r2_min     <= 1'b0;
            r2_inexact <= 1'b0;
            r2_mag     <= '0;
        end else if (w_en) begin
            r2_valid   <= r1_valid;
            r2_sign    <= r1_sign;
            r2_invalid <= r1_nan;
            r2_sat     <= w_sat;
            r2_min     <= w_min;
            r2_inexact <= w_inexact;
            r2_mag     <= w_mag;
        end
    end

    // S3 datapath: apply sign, or substitute saturation / NaN values.
    always_comb begin
        w_mag_n = NINT'(r2_mag);
        if (r2_invalid)
            w_result = '0;
        else if (r2_sat)
            w_result = r2_sign ? MIN_NEG : MAX_POS;
        else if (r2_min)
            w_result = MIN_NEG;
        else if (r2_sign)
            w_result = -w_mag_n;
        else
            w_result = w_mag_n;
    end

    // S3: output register, held while the consumer stalls.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_invalid  <= 1'b0;
            r_out_overflow <= 1'b0;
            r_out_inexact  <= 1'b0;
        end else if (w_en) begin
            r_out_valid    <= r2_valid;
            r_out_data     <= w_result;
            r_out_invalid  <= r2_invalid;
            r_out_overflow <= r2_sat;
            r_out_inexact  <= r2_inexact;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_invalid  = r_out_invalid;
    assign out_overflow = r_out_overflow;
    assign out_inexact  = r_out_inexact;

endmodule

// File: tb/tb_fp_to_int.sv
// tb_fp_to_int: directed checks of fp_to_int with NX=8, NM=23, NINT=32.
module tb_fp_to_int;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_invalid;
    logic        out_overflow;
    logic        out_inexact;

    int n_checks = 0;
    int n_fail   = 0;

    fp_to_int #(.NX(8), .NM(23), .NINT(32)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_invalid  (out_invalid),
        .out_overflow (out_overflow),
        .out_inexact  (out_inexact)
    );

    always #5 CLK = ~CLK;

    // Expected values packed as {data, invalid, overflow, inexact}.
    logic [31:0] v_in  [0:15] = '{
        32'h3FC00000, 32'hC2F60000, 32'h00000001, 32'h80000000,
        32'h4F000000, 32'hCF000000, 32'h4EFFFFFF, 32'h7FC00000,
        32'hFF800000, 32'h3F000000, 32'h4B000001, 32'hCF800000,
        32'h7F800000, 32'hC0490FDB, 32'h3F800000, 32'hCF000001
    };
    logic [34:0] v_exp [0:15] = '{
        {32'h00000001, 3'b001}, {32'hFFFFFF85, 3'b000},
        {32'h00000000, 3'b001}, {32'h00000000, 3'b000},
        {32'h7FFFFFFF, 3'b010}, {32'h80000000, 3'b000},
        {32'h7FFFFF80, 3'b000}, {32'h00000000, 3'b100},
        {32'h80000000, 3'b010}, {32'h00000000, 3'b001},
        {32'h00800001, 3'b000}, {32'h80000000, 3'b010},
        {32'h7FFFFFFF, 3'b010}, {32'hFFFFFFFD, 3'b001},
        {32'h00000001, 3'b000}, {32'h80000000, 3'b010}
    };

    logic [31:0] bp_in  [0:5] = '{
        32'h3F800000, 32'hC2F60000, 32'h4F000000,
        32'h3F000000, 32'h4B000001, 32'hC0490FDB
    };
    logic [34:0] bp_exp [0:5] = '{
        {32'h00000001, 3'b000}, {32'hFFFFFF85, 3'b000},
        {32'h7FFFFFFF, 3'b010}, {32'h00000000, 3'b001},
        {32'h00800001, 3'b000}, {32'hFFFFFFFD, 3'b001}
    };

    task automatic test_reset();
        RST       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        n_checks++;
        if (out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_out_data: got %h want 00000000", out_data);
        end
        n_checks++;
        if ({out_invalid, out_overflow, out_inexact} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000", {out_invalid, out_overflow, out_inexact});
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    // One word at a time: checks the 3-edge latency and the converted value.
    task automatic test_vectors();
        int edges;
        for (int i = 0; i < 16; i++) begin
            @(posedge CLK);
            #1;
            in_valid = 1'b1;
            in_data  = v_in[i];
            @(posedge CLK);
            #1;
            in_valid = 1'b0;
            edges = 1;
            while (out_valid !== 1'b1 && edges < 6) begin
                @(posedge CLK);
                #1;
                edges++;
            end
            n_checks++;
            if (edges != 3) begin
                n_fail++;
                $display("FAIL vec%0d_latency: got %0d edges want 3", i, edges);
            end
            n_checks++;
            if ({out_data, out_invalid, out_overflow, out_inexact} !== v_exp[i]) begin
                n_fail++;
                $display("FAIL vec%0d_value in=%h: got %h/%b want %h/%b", i, v_in[i],
                         out_data, {out_invalid, out_overflow, out_inexact},
                         v_exp[i][34:3], v_exp[i][2:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          idx = 0;
        int          nout = 0;
        int          nstall = 0;
        logic        stalled_prev = 1'b0;
        logic        acc;
        logic [34:0] obs;
        logic [34:0] held = '0;
        @(posedge CLK);
        #1;
        for (int c = 0; c < 40 && nout < 6; c++) begin
            out_ready = !(c >= 4 && c <= 7);
            if (idx < 6) begin
                in_valid = 1'b1;
                in_data  = bp_in[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            obs = {out_data, out_invalid, out_overflow, out_inexact};
            n_checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                n_fail++;
                $display("FAIL bp_in_ready c=%0d: got %b want %b", c, in_ready, !(out_valid && !out_ready));
            end
            if (in_ready === 1'b0) nstall++;
            if (stalled_prev) begin
                n_checks++;
                if (out_valid !== 1'b1 || obs !== held) begin
                    n_fail++;
                    $display("FAIL bp_stable c=%0d: got v=%b %h want v=1 %h", c, out_valid, obs, held);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_checks++;
                if (obs !== bp_exp[nout]) begin
                    n_fail++;
                    $display("FAIL bp_out%0d: got %h want %h", nout, obs, bp_exp[nout]);
                end
                nout++;
            end
            stalled_prev = (out_valid === 1'b1) && !out_ready;
            held = obs;
            acc  = in_valid && (in_ready === 1'b1);
            @(posedge CLK);
            #1;
            if (acc) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (nout != 6) begin
            n_fail++;
            $display("FAIL bp_count: got %0d results want 6", nout);
        end
        n_checks++;
        if (nstall == 0) begin
            n_fail++;
            $display("FAIL bp_stall_seen: got %0d stalled cycles want >0", nstall);
        end
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_no_dup k=%0d: got out_valid %b want 0", k, out_valid);
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        int   edges;
        logic stale = 1'b0;
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b1;
        in_data  = 32'hC2F60000;
        @(posedge CLK);
        #1;
        in_data  = 32'h4F000000;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        RST      = 1'b1;
        @(posedge CLK);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_valid: got %b want 0", out_valid);
        end
        RST = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge CLK);
            #1;
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        n_checks++;
        if (stale) begin
            n_fail++;
            $display("FAIL rst_mid_stale: got stale result want none");
        end
        in_valid = 1'b1;
        in_data  = 32'h3F800000;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        edges = 1;
        while (out_valid !== 1'b1 && edges < 6) begin
            @(posedge CLK);
            #1;
            edges++;
        end
        n_checks++;
        if (edges != 3) begin
            n_fail++;
            $display("FAIL rst_mid_latency: got %0d edges want 3", edges);
        end
        n_checks++;
        if ({out_data, out_invalid, out_overflow, out_inexact} !== {32'h00000001, 3'b000}) begin
            n_fail++;
            $display("FAIL rst_mid_value: got %h/%b want 00000001/000", out_data,
                     {out_invalid, out_overflow, out_inexact});
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
